// File: rtl/aesha_pkg.sv
// Shared types and widths for the AESHA core scheduler.
package aesha_pkg;

  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned DATA_W    = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                 aes_or_keccak;
    logic                 enc_or_dec;
    logic [AES_KEY_W-1:0] key;
    logic [DATA_W-1:0]    data;
  } core_cmd_t;

endpackage

// File: rtl/aesha_sched_if.sv
// Requester request/response channels plus the crypto-core operand/status bundle.
interface aesha_sched_if
  import aesha_pkg::*;
#(
  parameter int unsigned N_REQ = 2
) ();

  logic [N_REQ-1:0]           i_req_valid;
  logic [N_REQ-1:0]           o_req_ready;
  logic [N_REQ-1:0]           i_req_aes_or_keccak;
  logic [N_REQ-1:0]           i_req_enc_or_dec;
  logic [N_REQ*AES_KEY_W-1:0] i_req_key;
  logic [N_REQ*DATA_W-1:0]    i_req_data;
  logic [N_REQ-1:0]           o_rsp_valid;
  logic [N_REQ-1:0]           i_rsp_ready;
  logic [DATA_W-1:0]          o_rsp_data;
  logic                       o_rsp_err;
  logic                       o_core_start;
  logic                       o_core_aes_or_keccak;
  logic                       o_core_enc_or_dec;
  logic [AES_KEY_W-1:0]       o_core_key;
  logic [DATA_W-1:0]          o_core_data;
  logic [DATA_W-1:0]          i_core_data;
  logic                       i_core_busy;
  logic                       i_core_done;
  logic                       o_busy;

  // Scheduler side
  modport slave (
    input  i_req_valid, i_req_aes_or_keccak, i_req_enc_or_dec, i_req_key, i_req_data,
    input  i_rsp_ready, i_core_data, i_core_busy, i_core_done,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_core_start, o_core_aes_or_keccak, o_core_enc_or_dec, o_core_key, o_core_data,
    output o_busy
  );

  // Requesters and core side
  modport master (
    output i_req_valid, i_req_aes_or_keccak, i_req_enc_or_dec, i_req_key, i_req_data,
    output i_rsp_ready, i_core_data, i_core_busy, i_core_done,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_core_start, o_core_aes_or_keccak, o_core_enc_or_dec, o_core_key, o_core_data,
    input  o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic             valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aesha_sched.sv
// Round-robin scheduler sharing one AESHA crypto core between N_REQ requesters,
// with a watchdog that turns a missing done into an error response.
module aesha_sched
  import aesha_pkg::*;
#(
  parameter  int unsigned N_REQ          = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES),
  localparam int unsigned PTR_W          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input logic          i_clk,
  input logic          i_reset_n,
  aesha_sched_if.slave bus
);

  sched_state_t      state;
  sched_state_t      state_nxt;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  owner;
  logic [PTR_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  wd;
  logic [N_REQ-1:0]  grant;
  logic              grant_valid;
  logic [N_REQ-1:0]  owner_oh;
  core_cmd_t         cmd;
  core_cmd_t         sel_cmd;
  logic              core_start;
  logic              busy;
  logic [N_REQ-1:0]  rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              accept;
  logic              done_ok;
  logic              timeout;
  logic              rsp_hs;
  logic              unused_core_busy;

  assign unused_core_busy = bus.i_core_busy;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (bus.i_req_valid),
    .ptr   (ptr),
    .grant (grant),
    .valid (grant_valid)
  );

  // Operand mux for the granted requester
  always_comb begin
    sel_cmd = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_cmd.aes_or_keccak = bus.i_req_aes_or_keccak[i];
        sel_cmd.enc_or_dec    = bus.i_req_enc_or_dec[i];
        sel_cmd.key           = bus.i_req_key[AES_KEY_W*i +: AES_KEY_W];
        sel_cmd.data          = bus.i_req_data[DATA_W*i +: DATA_W];
        sel_idx               = PTR_W'(i);
      end
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next state and transaction strobes
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    timeout   = 1'b0;
    rsp_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (bus.i_core_done) begin
          done_ok   = 1'b1;
          state_nxt = RESP;
        end else if (wd == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready[owner]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latches, watchdog and response registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      ptr        <= '0;
      owner      <= '0;
      wd         <= '0;
      cmd        <= '0;
      core_start <= 1'b0;
      busy       <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      core_start <= accept;
      busy       <= (state_nxt != IDLE);
      if (accept) begin
        cmd   <= sel_cmd;
        owner <= sel_idx;
      end
      if (state == ISSUE)     wd <= '0;
      else if (state == WAIT) wd <= wd + CNT_W'(1);
      if (done_ok) begin
        rsp_data  <= bus.i_core_data;
        rsp_err   <= 1'b0;
        rsp_valid <= owner_oh;
      end else if (timeout) begin
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= owner_oh;
      end
      if (rsp_hs) begin
        rsp_valid <= '0;
        ptr       <= PTR_W'((32'(owner) + 32'd1) % N_REQ);
      end
    end
  end

  // Ready is the only combinational output; forced low while reset is asserted
  assign bus.o_req_ready          = ((state == IDLE) && i_reset_n) ? grant : '0;
  assign bus.o_rsp_valid          = rsp_valid;
  assign bus.o_rsp_data           = rsp_data;
  assign bus.o_rsp_err            = rsp_err;
  assign bus.o_core_start         = core_start;
  assign bus.o_core_aes_or_keccak = cmd.aes_or_keccak;
  assign bus.o_core_enc_or_dec    = cmd.enc_or_dec;
  assign bus.o_core_key           = cmd.key;
  assign bus.o_core_data          = cmd.data;
  assign bus.o_busy               = busy;

endmodule

// File: doc/aesha_sched.md
Name: aesha_sched

Overview:
Round-robin scheduler that shares one AESHA_top crypto core (AES-128 / Keccak) between N_REQ requesters. It accepts one request per requester through a valid/ready handshake and latches its mode, direction, key and data. It then drives the core's start and operand signals, waits for done (with a watchdog), and returns the 512-bit result to the owning requester over a valid/ready response channel. It sits between the bus-side request masters and AESHA_top.

Parameters:
N_REQ, 2, number of requesters (2..8).
TIMEOUT_CYCLES, 4096, max cycles waited in WAIT before an error response (>=4).
CNT_W, $clog2(TIMEOUT_CYCLES), watchdog counter width (derived, not overridden).

Ports:
i_clk  in  1  clock, rising edge.
i_reset_n  in  1  reset, asynchronous, active-low.
i_req_valid  in  N_REQ  per-requester request valid.
o_req_ready  out  N_REQ  per-requester request accept; at most one bit high.
i_req_aes_or_keccak  in  N_REQ  per-requester mode: 1 = AES, 0 = Keccak.
i_req_enc_or_dec  in  N_REQ  per-requester AES direction: 1 = enc, 0 = dec; ignored for Keccak.
i_req_key  in  N_REQ*128  per-requester key; slice i = [128*i +: 128].
i_req_data  in  N_REQ*512  per-requester data; slice i = [512*i +: 512].
o_rsp_valid  out  N_REQ  per-requester response valid; at most one bit high.
i_rsp_ready  in  N_REQ  per-requester response accept.
o_rsp_data  out  512  response payload, shared by all requesters, qualified by o_rsp_valid.
o_rsp_err  out  1  response is a watchdog timeout, qualified by o_rsp_valid.
o_core_start  out  1  one-cycle start pulse to the core.
o_core_aes_or_keccak  out  1  latched mode to the core.
o_core_enc_or_dec  out  1  latched direction to the core.
o_core_key  out  128  latched key to the core.
o_core_data  out  512  latched data to the core.
i_core_data  in  512  core result.
i_core_busy  in  1  core busy; status only, not used for sequencing.
i_core_done  in  1  core completion, sampled in WAIT only.
o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0. State = IDLE, RR pointer = 0, latched operands = 0, watchdog = 0, owner = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g is the first i with i_req_valid[i] = 1, searching from the RR pointer upward and wrapping at N_REQ.
  - o_req_ready[g] = 1, combinational from i_req_valid and the pointer. All other ready bits = 0.
  - On the handshake, latch g's mode, direction, key and data into the o_core_* registers, set owner = g, and go to ISSUE.
  - With no valid requests, stay in IDLE.
- ISSUE: o_core_start = 1 for exactly this cycle. Clear the watchdog. Go to WAIT. i_core_done is ignored here.
- WAIT:
  - Watchdog increments every cycle.
  - If i_core_done = 1: latch o_rsp_data = i_core_data and o_rsp_err = 0; go to RESP.
  - Else if watchdog == TIMEOUT_CYCLES-1: latch o_rsp_data = 0 and o_rsp_err = 1; go to RESP.
  - If done and timeout occur in the same cycle, done wins (err = 0).
- RESP:
  - o_rsp_valid[owner] = 1, held along with o_rsp_data and o_rsp_err until i_rsp_ready[owner] = 1. i_rsp_ready bits of other requesters are ignored.
  - On the handshake: pointer = (owner+1) mod N_REQ, go to IDLE. No new request is accepted in the handshake cycle.
- o_core_* operands stay stable from ISSUE until the next accept, so they are safe for a core that samples late.
- Latency: request handshake at edge 0, o_core_start high in cycle 1, done seen at edge k (k >= 2), o_rsp_valid high from cycle k+1. Minimum request-to-response is 3 cycles.
- Fairness: a requester that holds valid is served within N_REQ-1 other transactions.
- Requesters may drop valid before they are granted; the scheduler does not hold a grant across cycles.
- Reset mid-operation: immediate return to the reset values. o_core_start drops and the in-flight response is lost. The core has its own reset.
- No pipelining: one transaction in flight.

Decomposition:
- Package aesha_pkg holds:
  - typedef sched_state_t (IDLE, ISSUE, WAIT, RESP);
  - localparams AES_KEY_W = 128 and DATA_W = 512;
  - typedef core_cmd_t, a packed struct {aes_or_keccak, enc_or_dec, key, data}.
- One sub-module, rr_arbiter (N parameter; inputs req and ptr; outputs a one-hot grant and a valid flag), purely combinational and reusable.
- FSM, latches and watchdog stay in aesha_sched.

Test Plan:
- Single AES request: requester 0 sends key = 128'h0 and data = 512'h1; the core model returns data = 512'hABCD with done 5 cycles after start. Required: exactly one o_core_start pulse, o_rsp_valid[0] the cycle after done, o_rsp_data = 512'hABCD, o_rsp_err = 0.
- Simultaneous requests from 0 and 1, both held continuously: service order is 0, 1, 0, 1 over 4 transactions, and o_req_ready is never high on both bits at once.
- Back-pressure: hold i_rsp_ready[1] = 0 for 10 cycles. Required: o_rsp_valid[1] and o_rsp_data are stable throughout, i_rsp_ready[0] = 1 has no effect, and no new accept happens until the handshake.
- Timeout: core never raises done and TIMEOUT_CYCLES = 16. Required: o_rsp_err = 1 with o_rsp_data = 0 exactly 16 cycles after start. A done pulse on the same cycle as the final watchdog count gives err = 0.
- Done during ISSUE: raise i_core_done in the start cycle. Required: it is ignored and the FSM stays in WAIT.
- Reset in WAIT: pulse i_reset_n low. Required: all outputs are 0 asynchronously, and after release requester 0 has priority and the next transaction completes normally.
